// File: rtl/alu_pkg.sv
// Shared ALU opcodes, instruction field positions and small decode helpers
// used by the issue stage and its register file.
package alu_pkg;

  localparam logic [3:0] OP_COMPLEMENT = 4'd0;
  localparam logic [3:0] OP_AND        = 4'd1;
  localparam logic [3:0] OP_XOR        = 4'd2;
  localparam logic [3:0] OP_OR         = 4'd3;
  localparam logic [3:0] OP_DEC        = 4'd4;
  localparam logic [3:0] OP_ADD        = 4'd5;
  localparam logic [3:0] OP_SUB        = 4'd6;
  localparam logic [3:0] OP_INC        = 4'd7;
  localparam logic [3:0] OP_LDI        = 4'd8;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 9;
  localparam int RS1_MSB = 8;
  localparam int RS1_LSB = 6;
  localparam int RS2_MSB = 5;
  localparam int RS2_LSB = 3;

  localparam logic [2:0] R0 = 3'd0;

  // Unary ALU ops never look at operand 2.
  function automatic logic op_ignores_op2(input logic [3:0] op);
    return (op == OP_COMPLEMENT) || (op == OP_DEC) || (op == OP_INC);
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// 8-entry register file: two async read ports, one sync write port,
// r0 hardwired to zero, async active-low clear.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [2:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [2:0]        raddr1,
  input  logic [2:0]        raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] mem [0:7];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) mem[i] <= '0;
    end else if (we && (waddr != R0)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == R0) ? '0 : mem[raddr1];
  assign rdata2 = (raddr2 == R0) ? '0 : mem[raddr2];

endmodule

// File: rtl/alu_issue_stage.sv
// Issue/writeback stage in front of the combinational ALU: decode, operand read,
// EX registers, result slot and illegal-op counter. ALU_ISSUE_FWD_EN enables forwarding.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 9,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_instr,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  output logic [3:0]        alu_control,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [2:0]        res_rd,
  output logic              res_zero,
  output logic [ERR_W-1:0]  err_cnt
);

  logic [3:0]        op;
  logic [2:0]        rd, rs1, rs2;
  logic [IMM_W-1:0]  imm;
  logic              legal, is_ldi, uses_rs1, uses_rs2, hazard;
  logic              ex_valid, adv, accept;
  logic [2:0]        ex_rd;
  logic [DATA_W-1:0] rf_rdata1, rf_rdata2, src1, src2;
  logic [DATA_W-1:0] op1_nxt, op2_nxt;
  logic [3:0]        ctrl_nxt;

  assign op  = in_instr[OP_MSB:OP_LSB];
  assign rd  = in_instr[RD_MSB:RD_LSB];
  assign rs1 = in_instr[RS1_MSB:RS1_LSB];
  assign rs2 = in_instr[RS2_MSB:RS2_LSB];
  assign imm = in_instr[IMM_W-1:0];

  assign legal    = (op <= OP_LDI);
  assign is_ldi   = (op == OP_LDI);
  assign uses_rs1 = legal && !is_ldi;
  assign uses_rs2 = legal && !is_ldi && !op_ignores_op2(op);
  assign hazard   = ex_valid && (ex_rd != R0) &&
                    ((uses_rs1 && (ex_rd == rs1)) || (uses_rs2 && (ex_rd == rs2)));

  assign adv    = ex_valid && (!res_valid || res_ready);
  assign accept = in_valid && in_ready;

  alu_regfile #(.DATA_W(DATA_W)) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (adv),
    .waddr  (ex_rd),
    .wdata  (alu_result),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rf_rdata1),
    .rdata2 (rf_rdata2)
  );

`ifdef ALU_ISSUE_FWD_EN
  // A dependent op can only be accepted on an adv cycle, so alu_result is the value being written back.
  assign in_ready = !ex_valid || adv;
  assign src1 = (ex_valid && (ex_rd != R0) && (ex_rd == rs1)) ? alu_result : rf_rdata1;
  assign src2 = (ex_valid && (ex_rd != R0) && (ex_rd == rs2)) ? alu_result : rf_rdata2;
`else
  assign in_ready = (!ex_valid || adv) && !hazard;
  assign src1 = rf_rdata1;
  assign src2 = rf_rdata2;
`endif

  assign op1_nxt  = is_ldi ? '0 : src1;
  assign op2_nxt  = is_ldi ? {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm} : src2;
  assign ctrl_nxt = is_ldi ? OP_OR : op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_rd       <= '0;
      alu_op1     <= '0;
      alu_op2     <= '0;
      alu_control <= '0;
    end else if (accept && legal) begin
      ex_valid    <= 1'b1;
      ex_rd       <= rd;
      alu_op1     <= op1_nxt;
      alu_op2     <= op2_nxt;
      alu_control <= ctrl_nxt;
    end else if (adv) begin
      ex_valid    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_rd    <= '0;
      res_zero  <= 1'b0;
    end else if (adv) begin
      res_valid <= 1'b1;
      res_data  <= alu_result;
      res_rd    <= ex_rd;
      res_zero  <= alu_zero;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (accept && !legal && (err_cnt != '1)) begin
      err_cnt <= err_cnt + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: bench-side ALU, sequential ISA reference
// model (register array + expected-result queue), directed and random scenarios.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic [31:0] alu_op1, alu_op2, alu_result;
  logic [3:0]  alu_control;
  logic        alu_zero;
  logic        res_valid, res_ready, res_zero;
  logic [31:0] res_data;
  logic [2:0]  res_rd;
  logic [7:0]  err_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  rd;
    logic        zero;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] beat_log[$];
  logic        zero_log[$];
  logic [31:0] reg_m [8];
  int          err_m;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_rd(res_rd),
    .res_zero(res_zero), .err_cnt(err_cnt)
  );

  // Sibling ALU
  always_comb begin
    alu_result = '0;
    case (alu_control)
      4'd0: alu_result = ~alu_op1;
      4'd1: alu_result = alu_op1 & alu_op2;
      4'd2: alu_result = alu_op1 ^ alu_op2;
      4'd3: alu_result = alu_op1 | alu_op2;
      4'd4: alu_result = alu_op1 - 32'd1;
      4'd5: alu_result = alu_op1 + alu_op2;
      4'd6: alu_result = alu_op1 - alu_op2;
      4'd7: alu_result = alu_op1 + 32'd1;
      default: alu_result = '0;
    endcase
  end
  assign alu_zero = (alu_result == 32'd0);

  function automatic logic [15:0] enc(input int op, input int rd, input int rs1, input int rs2);
    return {op[3:0], rd[2:0], rs1[2:0], rs2[2:0], 3'b000};
  endfunction

  function automatic logic [15:0] ldi(input int rd, input int imm);
    return {4'h8, rd[2:0], imm[8:0]};
  endfunction

  // Instruction-level reference: executes each accepted instruction in program order.
  task automatic model_accept(input logic [15:0] ins);
    int op, rd;
    logic [31:0] a, b, r;
    exp_t e;
    op = int'(ins[15:12]);
    rd = int'(ins[11:9]);
    a  = reg_m[ins[8:6]];
    b  = reg_m[ins[5:3]];
    if (op > 8) begin
      if (err_m < 255) err_m++;
    end else begin
      case (op)
        0: r = ~a;
        1: r = a & b;
        2: r = a ^ b;
        3: r = a | b;
        4: r = a - 1;
        5: r = a + b;
        6: r = a - b;
        7: r = a + 1;
        default: r = {{23{ins[8]}}, ins[8:0]};
      endcase
      e.data = r; e.rd = rd[2:0]; e.zero = (r == 0);
      exp_q.push_back(e);
      if (rd != 0) reg_m[rd] = r;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) reg_m[i] = '0;
    exp_q.delete();
    err_m = 0;
  endtask

  // One clock: drive at negedge, sample 1 ns later, score any result beat.
  task automatic cycle(input logic v, input logic [15:0] ins, input logic rr, output logic acc);
    exp_t e;
    @(negedge clk);
    in_valid = v; in_instr = ins; res_ready = rr;
    #1;
    acc = v && in_ready;
    if (res_valid && res_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected: got data=%h rd=%0d, required no beat", res_data, res_rd);
      end else begin
        e = exp_q.pop_front();
        if ({res_data, res_rd, res_zero} !== {e.data, e.rd, e.zero}) begin
          errors++;
          $display("FAIL beat: got data=%h rd=%0d zero=%b, required data=%h rd=%0d zero=%b",
                   res_data, res_rd, res_zero, e.data, e.rd, e.zero);
        end
      end
      beat_log.push_back(res_data);
      zero_log.push_back(res_zero);
    end
    if (acc) model_accept(ins);
  endtask

  task automatic issue(input logic [15:0] ins, input logic rr, output int tries);
    logic acc;
    acc = 1'b0; tries = 0;
    while (!acc && tries < 20) begin
      cycle(1'b1, ins, rr, acc);
      tries++;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL issue_timeout: instr %h not accepted in %0d cycles", ins, tries);
    end
  endtask

  task automatic drain();
    logic acc;
    int n;
    n = 0;
    while ((exp_q.size() != 0 || res_valid) && n < 50) begin
      cycle(1'b0, 16'h0, 1'b1, acc);
      n++;
    end
    cycle(1'b0, 16'h0, 1'b1, acc);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; res_ready = 1'b0;
    model_reset();
    #2;
    checks++;
    if ({res_valid, res_data, res_rd, res_zero, err_cnt, alu_op1, alu_op2, alu_control} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got res_valid=%b res_data=%h err=%0d op1=%h op2=%h ctl=%h, required all 0",
               res_valid, res_data, err_cnt, alu_op1, alu_op2, alu_control);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_add_sub();
    int t;
    logic [31:0] exp_d [4];
    exp_d = '{32'd5, 32'd3, 32'd8, 32'hFFFF_FFFE};
    beat_log.delete(); zero_log.delete();
    issue(ldi(1, 5), 1'b1, t);
    issue(ldi(2, 3), 1'b1, t);
    issue(enc(5, 3, 1, 2), 1'b1, t);
    issue(enc(6, 4, 2, 1), 1'b1, t);
    drain();
    checks++;
    if (beat_log.size() != 4) begin
      errors++;
      $display("FAIL add_sub_count: got %0d beats, required 4", beat_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (beat_log[i] !== exp_d[i] || zero_log[i] !== 1'b0) begin
          errors++;
          $display("FAIL add_sub_beat%0d: got %h zero=%b, required %h zero=0", i, beat_log[i], zero_log[i], exp_d[i]);
        end
      end
    end
  endtask

  task automatic test_dependency();
    int t1, t2, stall;
`ifdef ALU_ISSUE_FWD_EN
    stall = 0;
`else
    stall = 1;
`endif
    beat_log.delete(); zero_log.delete();
    issue(ldi(1, 9'h1FF), 1'b1, t1);
    issue(enc(7, 1, 1, 0), 1'b1, t2);
    drain();
    checks++;
    if (t2 != 1 + stall) begin
      errors++;
      $display("FAIL dep_issue_cycles: got %0d, required %0d", t2, 1 + stall);
    end
    checks++;
    if (beat_log.size() != 2 || beat_log[0] !== 32'hFFFF_FFFF || beat_log[1] !== 32'd0 || zero_log[1] !== 1'b1) begin
      errors++;
      $display("FAIL dep_results: got %0d beats first=%h, required FFFFFFFF then 0 zero=1",
               beat_log.size(), (beat_log.size() > 0) ? beat_log[0] : 32'hx);
    end
  endtask

  task automatic test_backpressure();
    int t;
    logic acc;
    beat_log.delete(); zero_log.delete();
    issue(ldi(5, 7), 1'b0, t);
    issue(ldi(6, 9), 1'b0, t);
    checks++;
    if (t != 1) begin
      errors++;
      $display("FAIL bp_second_accept: got %0d tries, required 1", t);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, ldi(7, 11), 1'b0, acc);
      checks++;
      if (acc !== 1'b0 || alu_op1 !== 32'd0 || alu_op2 !== 32'd9 || alu_control !== 4'd3) begin
        errors++;
        $display("FAIL bp_hold%0d: got acc=%b op1=%h op2=%h ctl=%h, required 0/0/9/3",
                 i, acc, alu_op1, alu_op2, alu_control);
      end
    end
    issue(ldi(7, 11), 1'b1, t);
    issue(enc(5, 3, 5, 6), 1'b1, t);
    issue(enc(5, 4, 7, 7), 1'b1, t);
    drain();
    checks++;
    if (beat_log.size() != 5 || beat_log[0] !== 32'd7 || beat_log[1] !== 32'd9 || beat_log[2] !== 32'd11 ||
        beat_log[3] !== 32'd16 || beat_log[4] !== 32'd22) begin
      errors++;
      $display("FAIL bp_order: got %0d beats, required 7,9,11,16,22", beat_log.size());
    end
  endtask

  task automatic test_illegal();
    logic acc;
    int not_ready, seen;
    not_ready = 0; seen = 0;
    for (int i = 0; i < 300; i++) begin
      cycle(1'b1, {4'hA, 12'($urandom)}, 1'b1, acc);
      if (!acc) not_ready++;
      if (res_valid) seen++;
    end
    cycle(1'b0, 16'h0, 1'b1, acc);
    checks++;
    if (not_ready != 0) begin
      errors++;
      $display("FAIL illegal_in_ready: got %0d stalled cycles, required 0", not_ready);
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL illegal_res_valid: got %0d result cycles, required 0", seen);
    end
    checks++;
    if (err_cnt !== 8'd255) begin
      errors++;
      $display("FAIL illegal_err_cnt: got %0d, required 255", err_cnt);
    end
  endtask

  task automatic test_r0();
    int t;
    beat_log.delete(); zero_log.delete();
    issue(ldi(1, 4), 1'b1, t);
    issue(ldi(2, 6), 1'b1, t);
    issue(enc(5, 0, 1, 2), 1'b1, t);
    issue(enc(3, 3, 0, 0), 1'b1, t);
    drain();
    checks++;
    if (beat_log.size() != 4 || beat_log[2] !== 32'd10 || beat_log[3] !== 32'd0 || zero_log[3] !== 1'b1) begin
      errors++;
      $display("FAIL r0_target: got %0d beats, required ...,10,0 with zero on last", beat_log.size());
    end
  endtask

  task automatic test_random();
    logic acc;
    logic [15:0] ins;
    for (int i = 0; i < 400; i++) begin
      ins = 16'($urandom);
      ins[15:12] = 4'($urandom_range(0, 10));
      cycle(($urandom % 4) != 0, ins, ($urandom % 3) != 0, acc);
    end
    drain();
    checks++;
    if (err_cnt !== 8'(err_m)) begin
      errors++;
      $display("FAIL random_err_cnt: got %0d, required %0d", err_cnt, err_m);
    end
  endtask

  task automatic test_reset_mid_stall();
    int t;
    issue(ldi(1, 100), 1'b0, t);
    issue(ldi(2, 50), 1'b0, t);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({res_valid, res_data, res_rd, res_zero, err_cnt, alu_op1, alu_op2, alu_control} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got res_valid=%b res_data=%h err=%0d op2=%h, required all 0",
               res_valid, res_data, err_cnt, alu_op2);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    beat_log.delete(); zero_log.delete();
    issue(enc(5, 4, 1, 2), 1'b1, t);
    checks++;
    if (t != 1) begin
      errors++;
      $display("FAIL midreset_first_accept: got %0d tries, required 1", t);
    end
    drain();
    checks++;
    if (beat_log.size() != 1 || beat_log[0] !== 32'd0 || zero_log[0] !== 1'b1) begin
      errors++;
      $display("FAIL midreset_regfile: got %0d beats first=%h, required one beat 0",
               beat_log.size(), (beat_log.size() > 0) ? beat_log[0] : 32'hx);
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_dependency();
    test_backpressure();
    test_r0();
    test_illegal();
    test_random();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
